// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART word arbiter slice.
//   uart_idw()  - grant-index width for a given requester count (min 1 bit)
//   TAG_NIBBLE  - upper nibble of the optional source-tag byte
//   state_t     - arbiter FSM encoding; TAG states exist only when
//                 UART_ARB_SRC_TAG_EN is defined.
package uart_pkg;

  function automatic int uart_idw(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

`ifdef UART_ARB_SRC_TAG_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TAG, S_WAIT_TAG, S_SEND_LO, S_WAIT_LO, S_SEND_HI, S_WAIT_HI
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND_LO, S_WAIT_LO, S_SEND_HI, S_WAIT_HI
  } state_t;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req       in  NREQ  request vector
//   ptr       in  IDW   last granted index; search starts at ptr+1
//   grant_id  out IDW   first set req at ptr+1, ptr+2, ... (mod NREQ)
//   grant_vld out 1     any req set
module rr_arbiter import uart_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = uart_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_vld
);

  // Walk the offsets farthest-first so the nearest hit overwrites last.
  // Only indices 0..NREQ-1 are ever produced, so non-power-of-2 NREQ is safe.
  always_comb begin
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == (int'(ptr) + k) % NREQ)) begin
          grant_id  = IDW'(i);
          grant_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_word_arbiter.sv
// uart_tx_word_arbiter: shares one UART byte transmitter between NREQ
// 16-bit word requesters. Round-robin grant, ack on capture, then the
// low byte and the high byte go out with a tx_dv / tx_busy handshake.
// Optional macro UART_ARB_SRC_TAG_EN prefixes each frame with the tag
// byte {4'hA, 1'b0, grant_id[2:0]}.
//   clk, rst   clock, asynchronous active-high reset
//   ce         clock enable; all state and outputs hold while low
//   req        per-requester level request
//   word_in    requester i word on [16*i+15:16*i]
//   ack        one-cycle pulse when requester word is captured
//   tx_busy    UART busy, rises within one cycle of tx_dv
//   tx_dv      one-cycle byte-valid pulse
//   tx_byte    byte to send, held until the next tx_dv
//   grant_id   requester currently served
//   busy       high whenever the FSM is not idle
module uart_tx_word_arbiter import uart_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = uart_idw(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   word_in,
  output logic [NREQ-1:0]      ack,
  input  logic                 tx_busy,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [15:0]     word_q, word_d;
  logic            guard_q, guard_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            tx_dv_q, tx_dv_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            busy_q, busy_d;

  logic [IDW-1:0]  arb_id;
  logic            arb_vld;
  logic [15:0]     sel_word;
  logic            sel_req;
  logic [NREQ-1:0] grant_oh;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant_id  (arb_id),
    .grant_vld (arb_vld)
  );

  // Granted requester's word, request level and one-hot select.
  always_comb begin
    sel_word = 16'h0;
    sel_req  = 1'b0;
    grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        sel_word    = word_in[16*i +: 16];
        sel_req     = req[i];
        grant_oh[i] = 1'b1;
      end
    end
  end

`ifdef UART_ARB_SRC_TAG_EN
  logic [2:0] grant3;
  assign grant3 = 3'(grant_q);
  localparam state_t FIRST_SEND = S_TAG;
`else
  localparam state_t FIRST_SEND = S_SEND_LO;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    word_d    = word_q;
    guard_d   = guard_q;
    ack_d     = '0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          grant_d = arb_id;
          state_d = S_LOAD;
        end
      end
      // A requester that dropped req before capture is forgotten:
      // no ack, pointer untouched, back to arbitration.
      S_LOAD: begin
        if (sel_req) begin
          word_d   = sel_word;
          ack_d    = grant_oh;
          rr_ptr_d = grant_q;
          state_d  = FIRST_SEND;
        end else begin
          state_d  = S_IDLE;
        end
      end
`ifdef UART_ARB_SRC_TAG_EN
      S_TAG: begin
        if (!tx_busy) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = {TAG_NIBBLE, 1'b0, grant3};
          guard_d   = 1'b1;
          state_d   = S_WAIT_TAG;
        end
      end
      S_WAIT_TAG: begin
        if (guard_q)       guard_d = 1'b0;
        else if (!tx_busy) state_d = S_SEND_LO;
      end
`endif
      S_SEND_LO: begin
        if (!tx_busy) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = word_q[7:0];
          guard_d   = 1'b1;
          state_d   = S_WAIT_LO;
        end
      end
      // First wait cycle ignores tx_busy: the UART may not have raised it yet.
      S_WAIT_LO: begin
        if (guard_q)       guard_d = 1'b0;
        else if (!tx_busy) state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (!tx_busy) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = word_q[15:8];
          guard_d   = 1'b1;
          state_d   = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (guard_q)       guard_d = 1'b0;
        else if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= IDW'(NREQ - 1);
      grant_q   <= '0;
      word_q    <= 16'h0;
      guard_q   <= 1'b0;
      ack_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      word_q    <= word_d;
      guard_q   <= guard_d;
      ack_q     <= ack_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign tx_dv    = tx_dv_q;
  assign tx_byte  = tx_byte_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule
